// File: rtl/vga_pixel_scanner.sv
// Raster-scan source for the VGA path: issues pixel coordinates, then re-aligns
// sync/blank with the colour returned by the object mux and drives the DAC pins.
module vga_pixel_scanner #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  redIn,
  input  logic [7:0]  greenIn,
  input  logic [7:0]  blueIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        activeArea,
  output logic        startOfFrame,
  output logic        hSyncN,
  output logic        vSyncN,
  output logic        blankN,
  output logic [7:0]  redOut,
  output logic [7:0]  greenOut,
  output logic [7:0]  blueOut
);

  localparam int unsigned CW      = 11;
  localparam int unsigned TW      = 3;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Timing tag carried down the delay line: {hsync_n, vsync_n, active}
  localparam logic [TW-1:0] TAG_IDLE = 3'b110;

  logic [CW-1:0] h_next_c;
  logic [CW-1:0] v_next_c;
  logic          h_sync_raw;
  logic          v_sync_raw;
  logic [TW-1:0] tag_raw_c;
  logic [TW-1:0] tag_dly_c;

  // Next raster position; vertical advances only on the horizontal wrap
  always_comb begin
    h_next_c = pixelX + CW'(1);
    v_next_c = pixelY;
    if (pixelX == H_LAST) begin
      h_next_c = '0;
      v_next_c = (pixelY == V_LAST) ? '0 : pixelY + CW'(1);
    end
  end

  // Counters plus decodes registered from the next position, so every
  // coordinate-aligned signal refers to the same pixel as pixelX/pixelY.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pixelX       <= '0;
      pixelY       <= '0;
      activeArea   <= 1'b0;
      startOfFrame <= 1'b0;
      h_sync_raw   <= 1'b1;
      v_sync_raw   <= 1'b1;
    end else begin
      pixelX       <= h_next_c;
      pixelY       <= v_next_c;
      activeArea   <= (h_next_c < H_VIS) && (v_next_c < V_VIS);
      startOfFrame <= (h_next_c == '0) && (v_next_c == '0);
      h_sync_raw   <= !((h_next_c >= HS_START) && (h_next_c < HS_END));
      v_sync_raw   <= !((v_next_c >= VS_START) && (v_next_c < VS_END));
    end
  end

  assign tag_raw_c = {h_sync_raw, v_sync_raw, activeArea};

  // Match the object-mux latency so timing meets its colour at the output register
  if (PIPE_DELAY == 0) begin : g_no_delay
    assign tag_dly_c = tag_raw_c;
  end else begin : g_delay
    logic [TW-1:0] dly_q [PIPE_DELAY];

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        for (int i = 0; i < int'(PIPE_DELAY); i++) begin
          dly_q[i] <= TAG_IDLE;
        end
      end else begin
        dly_q[0] <= tag_raw_c;
        for (int i = 1; i < int'(PIPE_DELAY); i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign tag_dly_c = dly_q[PIPE_DELAY-1];
  end

  // Pin register: sync, blank and blanked colour leave together
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hSyncN   <= 1'b1;
      vSyncN   <= 1'b1;
      blankN   <= 1'b0;
      redOut   <= 8'h00;
      greenOut <= 8'h00;
      blueOut  <= 8'h00;
    end else begin
      hSyncN   <= tag_dly_c[2];
      vSyncN   <= tag_dly_c[1];
      blankN   <= tag_dly_c[0];
      redOut   <= tag_dly_c[0] ? redIn   : 8'h00;
      greenOut <= tag_dly_c[0] ? greenIn : 8'h00;
      blueOut  <= tag_dly_c[0] ? blueIn  : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_pixel_scanner.sv
// Bench for vga_pixel_scanner: one default-timing instance plus three small-raster
// instances (PIPE_DELAY 0/1/3) checked every cycle against a closed-form raster model.
module tb_vga_pixel_scanner;

  localparam int NI = 4;
  localparam int unsigned PDS [3] = '{0, 1, 3};

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, pd;
  } tcfg_t;

  typedef struct {
    int x, y, red, green;
    bit act, sof, hs_n, vs_n, blank;
  } exp_t;

  typedef struct {
    int t, x, y;
    bit hs_n, blank;
    int red;
  } vec_t;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  logic [7:0]    r_in [NI];
  logic [7:0]    g_in [NI];
  logic [7:0]    b_in [NI];
  logic [10:0]   px   [NI];
  logic [10:0]   py   [NI];
  logic [NI-1:0] act, sof, hs, vs, bl;
  logic [7:0]    r_o  [NI];
  logic [7:0]    g_o  [NI];
  logic [7:0]    b_o  [NI];

  for (genvar g = 0; g < 3; g++) begin : g_small
    vga_pixel_scanner #(
      .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
      .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(2),
      .PIPE_DELAY(PDS[g])
    ) u_dut (
      .clk(clk), .resetN(resetN),
      .redIn(r_in[g]), .greenIn(g_in[g]), .blueIn(b_in[g]),
      .pixelX(px[g]), .pixelY(py[g]),
      .activeArea(act[g]), .startOfFrame(sof[g]),
      .hSyncN(hs[g]), .vSyncN(vs[g]), .blankN(bl[g]),
      .redOut(r_o[g]), .greenOut(g_o[g]), .blueOut(b_o[g])
    );
  end

  vga_pixel_scanner u_big (
    .clk(clk), .resetN(resetN),
    .redIn(r_in[3]), .greenIn(g_in[3]), .blueIn(b_in[3]),
    .pixelX(px[3]), .pixelY(py[3]),
    .activeArea(act[3]), .startOfFrame(sof[3]),
    .hSyncN(hs[3]), .vSyncN(vs[3]), .blankN(bl[3]),
    .redOut(r_o[3]), .greenOut(g_o[3]), .blueOut(b_o[3])
  );

  tcfg_t      cfg [NI];
  vec_t       vec [13];
  logic [7:0] b_prev [NI];
  int checks   = 0;
  int failures = 0;
  int t;
  int vs_run, hs_run, t656, last_sof;
  bit hs_prev3;

  // Expected outputs t clocks after reset release, derived from raster arithmetic
  function automatic exp_t model(input tcfg_t c, input int tt);
    exp_t e;
    int ht, vt, s, sx, sy;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    e.x   = tt % ht;
    e.y   = (tt / ht) % vt;
    e.act = (tt >= 1) && (e.x < c.ha) && (e.y < c.va);
    e.sof = (tt >= 1) && ((tt % (ht * vt)) == 0);
    e.hs_n = 1'b1; e.vs_n = 1'b1; e.blank = 1'b0; e.red = 0; e.green = 0;
    s = tt - c.pd - 1;
    if (s >= 0) begin
      sx = s % ht;
      sy = (s / ht) % vt;
      e.hs_n  = !((sx >= c.ha + c.hfp) && (sx < c.ha + c.hfp + c.hs));
      e.vs_n  = !((sy >= c.va + c.vfp) && (sy < c.va + c.vfp + c.vs));
      e.blank = (s >= 1) && (sx < c.ha) && (sy < c.va);
      if (e.blank) begin
        e.red   = sx % 256;
        e.green = sy % 256;
      end
    end
    return e;
  endfunction

  task automatic check(input string nm, input int inst, input int tt, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0d got=%0d expected=%0d", nm, inst, tt, got, expv);
    end
  endtask

  // Object-mux stand-in: colour for pixel p arrives PIPE_DELAY clocks later; junk outside
  task automatic drive(input int tt);
    int p, ht, vt;
    for (int i = 0; i < NI; i++) begin
      ht = cfg[i].ha + cfg[i].hfp + cfg[i].hs + cfg[i].hbp;
      vt = cfg[i].va + cfg[i].vfp + cfg[i].vs + cfg[i].vbp;
      p  = tt - cfg[i].pd;
      b_in[i] = 8'($urandom);
      if (p >= 1 && (p % ht) < cfg[i].ha && ((p / ht) % vt) < cfg[i].va) begin
        r_in[i] = 8'(p % ht);
        g_in[i] = 8'((p / ht) % vt);
      end else begin
        r_in[i] = 8'hFF;
        g_in[i] = 8'($urandom);
      end
    end
  endtask

  task automatic compare_all(input int tt);
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      e = model(cfg[i], tt);
      check("pixelX",       i, tt, int'(px[i]),  e.x);
      check("pixelY",       i, tt, int'(py[i]),  e.y);
      check("activeArea",   i, tt, int'(act[i]), int'(e.act));
      check("startOfFrame", i, tt, int'(sof[i]), int'(e.sof));
      check("hSyncN",       i, tt, int'(hs[i]),  int'(e.hs_n));
      check("vSyncN",       i, tt, int'(vs[i]),  int'(e.vs_n));
      check("blankN",       i, tt, int'(bl[i]),  int'(e.blank));
      check("redOut",       i, tt, int'(r_o[i]), e.red);
      check("greenOut",     i, tt, int'(g_o[i]), e.green);
      check("blueOut",      i, tt, int'(b_o[i]), e.blank ? int'(b_prev[i]) : 0);
    end
  endtask

  task automatic reset_trackers();
    vs_run = 0; hs_run = 0; t656 = -1; last_sof = -1; hs_prev3 = 1'b1;
  endtask

  // Multi-cycle properties: pulse widths, sync latency, frame period
  task automatic track(input int tt);
    if (!vs[1]) vs_run++;
    else if (vs_run > 0) begin check("vsync_low_len", 1, tt, vs_run, 2 * 19); vs_run = 0; end
    if (!hs[3]) hs_run++;
    else if (hs_run > 0) begin check("hsync_low_len", 3, tt, hs_run, 96); hs_run = 0; end
    if (int'(px[3]) == 656) t656 = tt;
    if (hs_prev3 && !hs[3] && t656 >= 0) check("hsync_fall_delay", 3, tt, tt - t656, 2);
    hs_prev3 = hs[3];
    if (sof[1]) begin
      if (last_sof >= 0) check("sof_period", 1, tt, tt - last_sof, 19 * 11);
      last_sof = tt;
    end
  endtask

  task automatic run(input int n, input bit use_table);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) b_prev[i] = b_in[i];
      t++;
      drive(t);
      @(negedge clk);
      compare_all(t);
      track(t);
      if (use_table) begin
        for (int j = 0; j < 13; j++) begin
          if (vec[j].t == t) begin
            check("vec_pixelX", 3, t, int'(px[3]),  vec[j].x);
            check("vec_pixelY", 3, t, int'(py[3]),  vec[j].y);
            check("vec_hSyncN", 3, t, int'(hs[3]),  int'(vec[j].hs_n));
            check("vec_blankN", 3, t, int'(bl[3]),  int'(vec[j].blank));
            check("vec_redOut", 3, t, int'(r_o[3]), vec[j].red);
          end
        end
      end
    end
  endtask

  initial begin
    // Default-timing landmarks: {t, pixelX, pixelY, hSyncN, blankN, redOut}
    vec[0]  = '{1,   1,   0, 1'b1, 1'b0, 0};
    vec[1]  = '{2,   2,   0, 1'b1, 1'b0, 0};
    vec[2]  = '{3,   3,   0, 1'b1, 1'b1, 1};
    vec[3]  = '{641, 641, 0, 1'b1, 1'b1, 127};
    vec[4]  = '{642, 642, 0, 1'b1, 1'b0, 0};
    vec[5]  = '{657, 657, 0, 1'b1, 1'b0, 0};
    vec[6]  = '{658, 658, 0, 1'b0, 1'b0, 0};
    vec[7]  = '{753, 753, 0, 1'b0, 1'b0, 0};
    vec[8]  = '{754, 754, 0, 1'b1, 1'b0, 0};
    vec[9]  = '{799, 799, 0, 1'b1, 1'b0, 0};
    vec[10] = '{800, 0,   1, 1'b1, 1'b0, 0};
    vec[11] = '{802, 2,   1, 1'b1, 1'b1, 0};
    vec[12] = '{803, 3,   1, 1'b1, 1'b1, 1};

    for (int i = 0; i < 3; i++) cfg[i] = '{10, 2, 3, 4, 6, 1, 2, 2, int'(PDS[i])};
    cfg[3] = '{640, 16, 96, 48, 480, 10, 2, 33, 1};

    resetN = 1'b0;
    t = 0;
    for (int i = 0; i < NI; i++) b_prev[i] = 8'h00;
    drive(0);
    reset_trackers();
    repeat (2) @(negedge clk);
    compare_all(0);
    resetN = 1'b1;

    run(1800 + int'($urandom_range(0, 200)), 1'b1);

    // Asynchronous reset mid-frame: outputs must drop before the next edge
    @(posedge clk); #2;
    resetN = 1'b0;
    #1;
    compare_all(0);
    repeat (3) begin
      @(negedge clk);
      compare_all(0);
    end
    resetN = 1'b1;
    t = 0;
    reset_trackers();
    drive(0);

    run(600, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
